// File: rtl/video_pkg.sv
// Shared constants and decode state encoding for the video_rx SPI display receiver.
package video_pkg;

    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

    localparam int COLS_DEFAULT  = 128;
    localparam int PAGES_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COL_LO  = 3'd1,
        ST_COL_HI  = 3'd2,
        ST_PAGE_LO = 3'd3,
        ST_PAGE_HI = 3'd4
    } state_e;

endpackage

// File: rtl/video_rx_shift.sv
// SPI-side synchronisers, sclk rising-edge detect and MSB-first byte shifter.
module video_rx_shift
    import video_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srst_i,
    input  logic       cs_i,
    input  logic       dc_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_dc_o
);

    // One synchroniser chain per stage, carrying {cs, dc, sclk, mosi} side by side
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic cs_s, dc_s, sclk_s, mosi_s;
    assign {cs_s, dc_s, sclk_s, mosi_s} = sync_q[SYNC_STAGES-1];

    logic       sclk_prev_q, sclk_prev_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] cnt_q, cnt_d;
    logic       bv_q, bv_d;
    logic [7:0] bdata_q, bdata_d;
    logic       bdc_q, bdc_d;
    logic       rise;

    assign rise = sclk_s & ~sclk_prev_q & ~cs_s;

    always_comb begin
        sclk_prev_d = sclk_s;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        bv_d        = 1'b0;
        bdata_d     = bdata_q;
        bdc_d       = bdc_q;
        if (cs_s) begin
            cnt_d = 3'd0;
        end else if (rise) begin
            shreg_d = {shreg_q[6:0], mosi_s};
            if (cnt_q == 3'd7) begin
                bv_d    = 1'b1;
                bdata_d = {shreg_q[6:0], mosi_s};
                bdc_d   = dc_s;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
        if (srst_i) begin
            sclk_prev_d = 1'b0;
            shreg_d     = '0;
            cnt_d       = '0;
            bv_d        = 1'b0;
            bdata_d     = '0;
            bdc_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sclk_prev_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bv_q        <= 1'b0;
            bdata_q     <= '0;
            bdc_q       <= 1'b0;
        end else begin
            sync_q      <= srst_i ? '0 : {sync_q[SYNC_STAGES-2:0], {cs_i, dc_i, sclk_i, mosi_i}};
            sclk_prev_q <= sclk_prev_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            bv_q        <= bv_d;
            bdata_q     <= bdata_d;
            bdc_q       <= bdc_d;
        end
    end

    assign byte_valid_o = bv_q;
    assign byte_data_o  = bdata_q;
    assign byte_dc_o    = bdc_q;

endmodule

// File: rtl/video_rx.sv
// SPI display-panel receiver: byte capture plus column/page address decode into framebuffer writes.
// Address decode and fb_*/frame_done are compiled in only with VIDEO_RX_ADDR_DECODE_EN defined.
module video_rx
    import video_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = COLS_DEFAULT,
    parameter int PAGES       = PAGES_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            video_rst,
    input  logic                            video_cs,
    input  logic                            video_dc,
    input  logic                            video_sclk,
    input  logic                            video_mosi,
    output logic                            byte_valid,
    output logic [7:0]                      byte_data,
    output logic                            byte_dc,
    output logic                            fb_we,
    output logic [$clog2(COLS*PAGES)-1:0]   fb_addr,
    output logic [7:0]                      fb_data,
    output logic                            frame_done
);

    localparam int AW = $clog2(COLS*PAGES);

    logic [SYNC_STAGES-1:0] vrst_q;
    logic                   srst;
    logic                   bv_raw;

    assign srst = ~vrst_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vrst_q <= '0;
        else        vrst_q <= {vrst_q[SYNC_STAGES-2:0], video_rst};
    end

    video_rx_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .srst_i      (srst),
        .cs_i        (video_cs),
        .dc_i        (video_dc),
        .sclk_i      (video_sclk),
        .mosi_i      (video_mosi),
        .byte_valid_o(bv_raw),
        .byte_data_o (byte_data),
        .byte_dc_o   (byte_dc)
    );

    assign byte_valid = bv_raw & ~srst;

`ifdef VIDEO_RX_ADDR_DECODE_EN
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic          is_cmd, is_data, col_wrap, page_wrap;

    assign is_cmd    = byte_valid & ~byte_dc;
    assign is_data   = byte_valid & byte_dc;
    assign col_wrap  = (col_q == col_end_q);
    assign page_wrap = (page_q == page_end_q);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_d       = page_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        if (is_cmd) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == CMD_COL_ADDR)       state_d = ST_COL_LO;
                    else if (byte_data == CMD_PAGE_ADDR) state_d = ST_PAGE_LO;
                end
                ST_COL_LO: begin
                    col_start_d = byte_data[CW-1:0];
                    col_d       = byte_data[CW-1:0];
                    state_d     = ST_COL_HI;
                end
                ST_COL_HI: begin
                    col_end_d = byte_data[CW-1:0];
                    state_d   = ST_IDLE;
                end
                ST_PAGE_LO: begin
                    page_start_d = byte_data[PW-1:0];
                    page_d       = byte_data[PW-1:0];
                    state_d      = ST_PAGE_HI;
                end
                ST_PAGE_HI: begin
                    page_end_d = byte_data[PW-1:0];
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (is_data) begin
            // Data mid-argument abandons the range update; fields already stored are kept
            state_d = ST_IDLE;
            if (col_wrap) begin
                col_d = col_start_q;
                if (page_wrap)                          page_d = page_start_q;
                else if (page_q == PW'(PAGES-1))        page_d = '0;
                else                                    page_d = page_q + 1'b1;
            end else if (col_q == CW'(COLS-1)) begin
                col_d = '0;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (srst) begin
            state_d      = ST_IDLE;
            col_d        = '0;
            col_start_d  = '0;
            col_end_d    = CW'(COLS-1);
            page_d       = '0;
            page_start_d = '0;
            page_end_d   = PW'(PAGES-1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            col_start_q  <= '0;
            col_end_q    <= CW'(COLS-1);
            page_q       <= '0;
            page_start_q <= '0;
            page_end_q   <= PW'(PAGES-1);
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_q       <= page_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
        end
    end

    assign fb_we      = is_data;
    assign fb_addr    = AW'(int'(page_q) * COLS + int'(col_q));
    assign fb_data    = byte_data;
    assign frame_done = is_data & col_wrap & page_wrap;
`else
    assign fb_we      = 1'b0;
    assign fb_addr    = '0;
    assign fb_data    = '0;
    assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_video_rx.sv
// Directed bench for video_rx: byte capture, range commands, wrap, cs abort and resets.
module tb_video_rx;

    localparam int SYNC = 2;
    localparam int AW   = 10;
`ifdef VIDEO_RX_ADDR_DECODE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, video_rst = 1'b1;
    logic cs = 1'b1, dc = 1'b0, sclk = 1'b0, mosi = 1'b0;
    logic          byte_valid, byte_dc, fb_we, frame_done;
    logic [7:0]    byte_data, fb_data;
    logic [AW-1:0] fb_addr;

    always #5 clk = ~clk;

    video_rx #(.SYNC_STAGES(SYNC), .COLS(128), .PAGES(8)) dut (
        .clk(clk), .rst_n(rst_n), .video_rst(video_rst),
        .video_cs(cs), .video_dc(dc), .video_sclk(sclk), .video_mosi(mosi),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done)
    );

    int checks = 0, failures = 0;

    int            n_bv, n_we, n_fd;
    logic [7:0]    cap_data, cap_fbdata;
    logic          cap_dc, cap_fd;
    logic [AW-1:0] cap_addr;

    always @(negedge clk) begin
        if (byte_valid) begin
            n_bv++;
            cap_data = byte_data;
            cap_dc   = byte_dc;
        end
        if (fb_we) begin
            n_we++;
            cap_addr   = fb_addr;
            cap_fbdata = fb_data;
            cap_fd     = frame_done;
        end
        if (frame_done) n_fd++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        n_bv = 0; n_we = 0; n_fd = 0;
        cap_data = '0; cap_dc = 1'b0; cap_addr = '0; cap_fbdata = '0; cap_fd = 1'b0;
    endtask

    task automatic spi_bit(input bit b, input int half);
        mosi = b;
        sclk = 1'b0;
        repeat (half) @(posedge clk);
        sclk = 1'b1;
        repeat (half) @(posedge clk);
    endtask

    task automatic send_byte(input bit d, input logic [7:0] v, input int half);
        @(posedge clk);
        dc = d;
        cs = 1'b0;
        for (int i = 7; i >= 0; i--) spi_bit(v[i], half);
        sclk = 1'b0;
        repeat (half + 8) @(posedge clk);
        cs = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    typedef struct {
        bit         dc;
        logic [7:0] data;
        bit         we;
        int         addr;
        bit         fd;
    } vec_t;

    vec_t vecs[25];

    initial begin
        #1_500_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 0,   1'b0};
        vecs[1]  = '{1'b0, 8'h21, 1'b0, 0,   1'b0};
        vecs[2]  = '{1'b0, 8'h10, 1'b0, 0,   1'b0};
        vecs[3]  = '{1'b0, 8'h11, 1'b0, 0,   1'b0};
        vecs[4]  = '{1'b0, 8'h22, 1'b0, 0,   1'b0};
        vecs[5]  = '{1'b0, 8'h03, 1'b0, 0,   1'b0};
        vecs[6]  = '{1'b0, 8'h03, 1'b0, 0,   1'b0};
        vecs[7]  = '{1'b1, 8'h01, 1'b1, 400, 1'b0};
        vecs[8]  = '{1'b1, 8'h02, 1'b1, 401, 1'b1};
        vecs[9]  = '{1'b1, 8'h03, 1'b1, 400, 1'b0};
        vecs[10] = '{1'b0, 8'h55, 1'b0, 0,   1'b0};
        vecs[11] = '{1'b1, 8'h5A, 1'b1, 401, 1'b1};
        vecs[12] = '{1'b0, 8'h21, 1'b0, 0,   1'b0};
        vecs[13] = '{1'b1, 8'h44, 1'b1, 400, 1'b0};
        vecs[14] = '{1'b1, 8'h99, 1'b1, 401, 1'b1};
        vecs[15] = '{1'b0, 8'h05, 1'b0, 0,   1'b0};
        vecs[16] = '{1'b1, 8'h66, 1'b1, 400, 1'b0};
        vecs[17] = '{1'b0, 8'h21, 1'b0, 0,   1'b0};
        vecs[18] = '{1'b0, 8'h7E, 1'b0, 0,   1'b0};
        vecs[19] = '{1'b0, 8'h01, 1'b0, 0,   1'b0};
        vecs[20] = '{1'b1, 8'hA0, 1'b1, 510, 1'b0};
        vecs[21] = '{1'b1, 8'hA1, 1'b1, 511, 1'b0};
        vecs[22] = '{1'b1, 8'hA2, 1'b1, 384, 1'b0};
        vecs[23] = '{1'b1, 8'hA3, 1'b1, 385, 1'b1};
        vecs[24] = '{1'b1, 8'hA4, 1'b1, 510, 1'b0};

        clr_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_valid", int'(byte_valid), 0);
        check("rst_fb_we",      int'(fb_we), 0);
        check("rst_fb_addr",    int'(fb_addr), 0);
        rst_n = 1'b1;
        repeat (SYNC + 4) @(posedge clk);
        @(negedge clk);
        check("post_rst_byte_data",  int'(byte_data), 0);
        check("post_rst_frame_done", int'(frame_done), 0);
        check("post_rst_fb_data",    int'(fb_data), 0);

        for (int k = 0; k < 25; k++) begin
            bit exp_we;
            bit exp_fd;
            exp_we = vecs[k].we & DEC;
            exp_fd = vecs[k].fd & DEC;
            clr_mon();
            send_byte(vecs[k].dc, vecs[k].data, 4);
            check($sformatf("v%0d_nvalid", k), n_bv, 1);
            check($sformatf("v%0d_data", k),   int'(cap_data), int'(vecs[k].data));
            check($sformatf("v%0d_dc", k),     int'(cap_dc), int'(vecs[k].dc));
            check($sformatf("v%0d_nwe", k),    n_we, int'(exp_we));
            check($sformatf("v%0d_addr", k),   int'(cap_addr), exp_we ? vecs[k].addr : 0);
            check($sformatf("v%0d_fbdata", k), int'(cap_fbdata), exp_we ? int'(vecs[k].data) : 0);
            check($sformatf("v%0d_nfd", k),    n_fd, int'(exp_fd));
        end

        // cs abort after five bits, then a clean byte
        clr_mon();
        @(posedge clk);
        dc = 1'b1;
        cs = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 4);
        sclk = 1'b0;
        repeat (4) @(posedge clk);
        cs = 1'b1;
        repeat (8) @(posedge clk);
        send_byte(1'b1, 8'h3C, 4);
        check("abort_nvalid", n_bv, 1);
        check("abort_data",   int'(cap_data), 8'h3C);
        check("abort_nwe",    n_we, int'(DEC));

        // video_rst mid-argument sequence
        send_byte(1'b0, 8'h21, 4);
        send_byte(1'b0, 8'h20, 4);
        @(posedge clk);
        video_rst = 1'b0;
        repeat (4) @(posedge clk);
        video_rst = 1'b1;
        repeat (SYNC + 4) @(posedge clk);
        clr_mon();
        send_byte(1'b1, 8'h77, 4);
        check("vrst_nvalid", n_bv, 1);
        check("vrst_nwe",    n_we, int'(DEC));
        check("vrst_addr0",  int'(cap_addr), 0);
        clr_mon();
        send_byte(1'b1, 8'h78, 4);
        check("vrst_addr1",  int'(cap_addr), DEC ? 1 : 0);

        // async reset clears held byte data without a clock edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_byte_data", int'(byte_data), 0);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        repeat (SYNC + 4) @(posedge clk);

        // full-frame wrap at clk/4
        begin
            int seq_err;
            seq_err = 0;
            clr_mon();
            for (int i = 0; i < 1024; i++) begin
                send_byte(1'b1, 8'(i), 2);
                if (int'(cap_addr) != (DEC ? i : 0)) seq_err++;
            end
            check("frame_seq_err",  seq_err, 0);
            check("frame_nvalid",   n_bv, 1024);
            check("frame_nwe",      n_we, DEC ? 1024 : 0);
            check("frame_last_addr", int'(cap_addr), DEC ? 1023 : 0);
            check("frame_last_fd",  int'(cap_fd), int'(DEC));
            check("frame_nfd",      n_fd, int'(DEC));
            send_byte(1'b1, 8'hEE, 2);
            check("frame_wrap_addr", int'(cap_addr), 0);
            check("frame_wrap_fd",   int'(cap_fd), 0);
            check("frame_wrap_nfd",  n_fd, int'(DEC));
            check("frame_wrap_nwe",  n_we, DEC ? 1025 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
